decoder_ah_2_4_mux: RTL and testbench

- Active-high 2-to-4 line decoder with enable, built as a behavioural multiplexer tree.
- Provides two outputs:
  - a zero-latency combinational one-hot output, for glue logic;
  - a registered copy with a valid flag, for timing-clean downstream consumers.
- Used wherever a 2-bit select must drive one of four active-high strobes.

---
 rtl/decoder_ah_2_4_mux_if.sv | 28 ++
 rtl/decoder_ah_2_4_mux.sv | 54 +++++
 tb/tb_decoder_ah_2_4_mux.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/decoder_ah_2_4_mux_if.sv
// Bundle for the 2-to-4 decoder: select/enable in, one-hot strobes out.
// The master drives select/enable; the slave is the decoder itself.
interface decoder_ah_2_4_mux_if #(
  parameter int SEL_W = 2,
  parameter int OUT_W = 4
);
  logic [SEL_W-1:0] sel_in;
  logic             en_in;
  logic [OUT_W-1:0] y_out;
  logic [OUT_W-1:0] y_reg_out;
  logic             valid_out;

  modport master (
    output sel_in,
    output en_in,
    input  y_out,
    input  y_reg_out,
    input  valid_out
  );

  modport slave (
    input  sel_in,
    input  en_in,
    output y_out,
    output y_reg_out,
    output valid_out
  );
endinterface

// File: rtl/decoder_ah_2_4_mux.sv
// Active-high 2-to-4 decoder with enable, built from per-bit 4:1 mux trees.
// Exposes a zero-latency one-hot output plus a registered copy qualified by valid.
module decoder_ah_2_4_mux #(
  parameter int SEL_W = 2,
  parameter int OUT_W = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  decoder_ah_2_4_mux_if.slave  bus
);

  if (SEL_W != 2) begin : g_bad_sel_w
    $error("decoder_ah_2_4_mux: SEL_W must be 2");
  end
  if (OUT_W != (2 ** SEL_W)) begin : g_bad_out_w
    $error("decoder_ah_2_4_mux: OUT_W must equal 2**SEL_W");
  end

  logic [OUT_W-1:0] y_comb;
  logic [OUT_W-1:0] y_reg;
  logic             valid_reg;

  // Each output bit has its own mux tree; only the leaf matching that bit's
  // index carries en_in, so a disabled decoder yields 0 even on an X select.
  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    logic [3:0] leaf;
    logic       lvl1_lo;
    logic       lvl1_hi;

    for (genvar k = 0; k < 4; k++) begin : g_leaf
      assign leaf[k] = (k == i) ? bus.en_in : 1'b0;
    end

    assign lvl1_lo   = bus.sel_in[0] ? leaf[1] : leaf[0];
    assign lvl1_hi   = bus.sel_in[0] ? leaf[3] : leaf[2];
    assign y_comb[i] = bus.sel_in[1] ? lvl1_hi : lvl1_lo;
  end

  // Pipeline copy updates every cycle; reset clears it without a clock.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_reg     <= '0;
      valid_reg <= 1'b0;
    end else begin
      y_reg     <= y_comb;
      valid_reg <= bus.en_in;
    end
  end

  assign bus.y_out     = y_comb;
  assign bus.y_reg_out = y_reg;
  assign bus.valid_out = valid_reg;

endmodule

// File: tb/tb_decoder_ah_2_4_mux.sv
// Bench for decoder_ah_2_4_mux: vector table for the decode, queue-based
// scoreboard for the registered path, and hand sequences for reset corners.
module tb_decoder_ah_2_4_mux;

  logic clk_in;
  logic rst_n_in;

  decoder_ah_2_4_mux_if #(.SEL_W(2), .OUT_W(4)) bus ();

  decoder_ah_2_4_mux #(.SEL_W(2), .OUT_W(4)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       en;
    logic [1:0] sel;
    logic [3:0] y;
  } vec_t;

  typedef struct {
    logic       valid;
    logic [3:0] y;
  } reg_exp_t;

  vec_t     vecs [8];
  reg_exp_t exp_q [$];
  int       total;
  int       bad;

  task automatic check_output(input string name, input logic [3:0] actual,
                              input logic [3:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic [1:0] sel);
    bus.en_in  = en;
    bus.sel_in = sel;
  endtask

  function automatic logic [3:0] model_y(input logic en, input logic [1:0] sel);
    logic [3:0] r;
    r = 4'b0000;
    if (en) r[sel] = 1'b1;
    return r;
  endfunction

  task automatic push_expected(input logic en, input logic [1:0] sel);
    reg_exp_t e;
    e.valid = en;
    e.y     = model_y(en, sel);
    exp_q.push_back(e);
  endtask

  task automatic pop_and_check(input string name);
    reg_exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s: got empty queue expected entry", name);
    end else begin
      total--;
      e = exp_q.pop_front();
      check_output({name, "_y_reg"}, bus.y_reg_out, e.y);
      check_output({name, "_valid"}, {3'b000, bus.valid_out}, {3'b000, e.valid});
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] step;
    total = 0;
    bad   = 0;

    vecs[0] = '{en: 1'b0, sel: 2'b00, y: 4'b0000};
    vecs[1] = '{en: 1'b0, sel: 2'b01, y: 4'b0000};
    vecs[2] = '{en: 1'b0, sel: 2'b10, y: 4'b0000};
    vecs[3] = '{en: 1'b0, sel: 2'b11, y: 4'b0000};
    vecs[4] = '{en: 1'b1, sel: 2'b00, y: 4'b0001};
    vecs[5] = '{en: 1'b1, sel: 2'b01, y: 4'b0010};
    vecs[6] = '{en: 1'b1, sel: 2'b10, y: 4'b0100};
    vecs[7] = '{en: 1'b1, sel: 2'b11, y: 4'b1000};

    // Reset held across edges: registered side stays clear, y_out follows inputs.
    rst_n_in = 1'b0;
    apply_stimulus(1'b1, 2'b10);
    #1;
    check_output("rst_y_reg", bus.y_reg_out, 4'b0000);
    check_output("rst_valid", {3'b000, bus.valid_out}, 4'b0000);
    check_output("rst_y_comb", bus.y_out, 4'b0100);
    repeat (2) @(posedge clk_in);
    #1;
    check_output("rst_hold_y_reg", bus.y_reg_out, 4'b0000);
    check_output("rst_hold_valid", {3'b000, bus.valid_out}, 4'b0000);

    // Release mid-cycle; first capture on the next rising edge.
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    check_output("pre_edge_y_reg", bus.y_reg_out, 4'b0000);
    check_output("pre_edge_valid", {3'b000, bus.valid_out}, 4'b0000);
    push_expected(1'b1, 2'b10);
    @(posedge clk_in);
    #1;
    pop_and_check("first_capture");

    // Table: combinational decode now, registered copy one edge later.
    foreach (vecs[n]) begin
      apply_stimulus(vecs[n].en, vecs[n].sel);
      push_expected(vecs[n].en, vecs[n].sel);
      #1;
      check_output($sformatf("vec%0d_y", n), bus.y_out, vecs[n].y);
      @(posedge clk_in);
      #1;
      pop_and_check($sformatf("vec%0d", n));
    end

    // Select sweeps: bit0 toggles every 10, bit1 every 20.
    for (int en = 0; en < 2; en++) begin
      for (int s = 0; s < 8; s++) begin
        step = 3'(s);
        apply_stimulus(en[0], step[1:0]);
        #5;
        check_output($sformatf("sweep_en%0d_s%0d", en, s), bus.y_out,
                     model_y(en[0], step[1:0]));
        #5;
      end
    end

    // Enable drop at sel=11 acts without a clock.
    @(posedge clk_in);
    #1;
    apply_stimulus(1'b1, 2'b11);
    #1;
    check_output("en_toggle_on", bus.y_out, 4'b1000);
    bus.en_in = 1'b0;
    #1;
    check_output("en_toggle_off", bus.y_out, 4'b0000);
    bus.en_in = 1'b1;
    #1;
    check_output("en_toggle_back", bus.y_out, 4'b1000);

    // Async reset between edges clears the register but not y_out.
    push_expected(1'b1, 2'b11);
    @(posedge clk_in);
    #1;
    pop_and_check("pre_async");
    #1;
    rst_n_in = 1'b0;
    #1;
    check_output("async_y_reg", bus.y_reg_out, 4'b0000);
    check_output("async_valid", {3'b000, bus.valid_out}, 4'b0000);
    check_output("async_y_comb", bus.y_out, 4'b1000);
    rst_n_in = 1'b1;
    push_expected(1'b1, 2'b11);
    @(posedge clk_in);
    #1;
    pop_and_check("post_async");

    // Unknown select with enable low must still decode to zero.
    bus.en_in  = 1'b0;
    bus.sel_in = 2'bxx;
    push_expected(1'b0, 2'b00);
    #1;
    check_output("x_sel_y", bus.y_out, 4'b0000);
    @(posedge clk_in);
    #1;
    pop_and_check("x_sel");

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL queue_drain: got %0d expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
